// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle controller that turns one decoded command into
// the read / execute / writeback control sequence for the 16-bit, 8-register datapath.
module datapath_sequencer #(
  parameter int DATA_W = 16,
  parameter int IMM_W = 8,
  parameter int RN_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_alu,
  input  logic [1:0]        cmd_shift,
  input  logic [RN_W-1:0]   cmd_rd,
  input  logic [RN_W-1:0]   cmd_rn,
  input  logic [RN_W-1:0]   cmd_rm,
  input  logic [IMM_W-1:0]  cmd_imm,
  input  logic              stall,
  output logic [RN_W-1:0]   readnum,
  output logic [RN_W-1:0]   writenum,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              write,
  output logic              vsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] datapath_in,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_MOVI = 3'd1, OP_MOVR = 3'd2, OP_ALU = 3'd3, OP_CMP = 3'd4;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;
  state_t state;
  logic [2:0] op;
  logic [1:0] alu, sh;
  logic [RN_W-1:0] rd, rn, rm;
  logic [IMM_W-1:0] imm;
  logic accept, run, is_cmp;
  assign cmd_ready = state == IDLE && !stall;
  assign accept = cmd_valid && cmd_ready;
  assign run = !stall;
  assign is_cmp = op == OP_CMP;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      {op, alu, sh, rd, rn, rm, imm} <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (accept) begin
        {op, alu, sh, rd, rn, rm, imm} <= {cmd_op, cmd_alu, cmd_shift, cmd_rd, cmd_rn, cmd_rm, cmd_imm};
        state <= cmd_op == OP_MOVI ? WB : cmd_op == OP_MOVR ? RD_B :
                 (cmd_op == OP_ALU || cmd_op == OP_CMP) ? RD_A : IDLE;
        done <= cmd_op == OP_NOP || cmd_op > OP_CMP;
        err <= cmd_op > OP_CMP;
      end else if (run && state != IDLE) begin
        state <= state == RD_A ? RD_B : state == RD_B ? EXEC :
                 (state == EXEC && !is_cmp) ? WB : IDLE;
        done <= state == WB || (state == EXEC && is_cmp);
      end
    end
  end
  // selects follow the held state during a stall; only the enables are gated
  assign readnum = state == RD_A ? rn : state == RD_B ? rm : '0;
  assign loada = state == RD_A && run;
  assign loadb = state == RD_B && run;
  assign shift = state == EXEC ? sh : 2'b00;
  assign asel = state == EXEC && op == OP_MOVR;
  assign bsel = 1'b0;
  assign ALUop = state != EXEC ? 2'b00 : is_cmp ? 2'b01 : op == OP_ALU ? alu : 2'b00;
  assign loadc = state == EXEC && !is_cmp && run;
  assign loads = state == EXEC && is_cmp && run;
  assign writenum = state == WB ? rd : '0;
  assign write = state == WB && run;
  assign vsel = state == WB && op == OP_MOVI;
  assign datapath_in = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign busy = state != IDLE;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed and random commands checked cycle by cycle, plus a
// behavioural datapath driven by the DUT controls and compared to command-level results.
module tb_datapath_sequencer;
  logic clk = 1'b0, resetn = 1'b0, cmd_valid = 1'b0, stall = 1'b0;
  logic [2:0] cmd_op = '0, cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
  logic [1:0] cmd_alu = '0, cmd_shift = '0;
  logic [7:0] cmd_imm = '0;
  logic cmd_ready, loada, loadb, loadc, loads, asel, bsel, write, vsel, busy, done, err;
  logic [2:0] readnum, writenum;
  logic [1:0] shift, ALUop;
  logic [15:0] datapath_in;

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_alu(cmd_alu), .cmd_shift(cmd_shift), .cmd_rd(cmd_rd),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm), .stall(stall),
    .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .write(write),
    .vsel(vsel), .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] alu, sh;
    logic [2:0] rd, rn, rm;
    logic [7:0] imm;
  } cmd_t;

  cmd_t cur = '0;
  int checks = 0, errors = 0;
  logic exp_done = 1'b0, exp_err = 1'b0, exp_z = 1'b0;
  logic [15:0] dp_r[8] = '{default: 16'd0};
  logic [15:0] exp_r[8] = '{default: 16'd0};
  logic [15:0] dp_a = '0, dp_b = '0, dp_c = '0;
  logic dp_z = 1'b0;

  wire [37:0] act = {readnum, writenum, loada, loadb, loadc, loads, asel, bsel, write, vsel,
                     shift, ALUop, datapath_in, busy, done, err, cmd_ready};

  function automatic logic [15:0] sext(logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] shf(logic [15:0] v, logic [1:0] s);
    case (s)
      2'd0: return v;
      2'd1: return v << 1;
      2'd2: return v >> 1;
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  function automatic logic [15:0] alu_f(logic [15:0] a, logic [15:0] b, logic [1:0] o);
    case (o)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return ~b;
    endcase
  endfunction

  // behavioural datapath: register file, A/B/C registers and status flag
  always @(posedge clk) begin
    if (write) dp_r[writenum] <= vsel ? datapath_in : dp_c;
    if (loada) dp_a <= dp_r[readnum];
    if (loadb) dp_b <= dp_r[readnum];
    if (loadc) dp_c <= alu_f(asel ? 16'd0 : dp_a, bsel ? datapath_in : shf(dp_b, shift), ALUop);
    if (loads) dp_z <= alu_f(asel ? 16'd0 : dp_a, bsel ? datapath_in : shf(dp_b, shift), ALUop) == 16'd0;
  end

  // phase: 0 idle, 1 read A, 2 read B, 3 execute, 4 writeback
  function automatic logic [37:0] exp_vec(int ph, bit st);
    logic [2:0] rdn, wn;
    logic [1:0] s, aop;
    logic la, lb, lc, ls, as, wr, vs;
    rdn = ph == 1 ? cur.rn : ph == 2 ? cur.rm : 3'd0;
    la = ph == 1 && !st;
    lb = ph == 2 && !st;
    lc = ph == 3 && cur.op != 3'd4 && !st;
    ls = ph == 3 && cur.op == 3'd4 && !st;
    as = ph == 3 && cur.op == 3'd2;
    s = ph == 3 ? cur.sh : 2'd0;
    aop = ph != 3 ? 2'd0 : cur.op == 3'd4 ? 2'd1 : cur.op == 3'd3 ? cur.alu : 2'd0;
    wn = ph == 4 ? cur.rd : 3'd0;
    wr = ph == 4 && !st;
    vs = ph == 4 && cur.op == 3'd1;
    return {rdn, wn, la, lb, lc, ls, as, 1'b0, wr, vs, s, aop, sext(cur.imm),
            ph != 0, exp_done, exp_err, ph == 0 && !st};
  endfunction

  task automatic check(string tag, logic [37:0] a, logic [37:0] e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, a, e);
    end
  endtask

  task automatic tick(int ph, bit st);
    stall = st;
    @(negedge clk);
    check($sformatf("cyc op%0d ph%0d st%0d", cur.op, ph, st), act, exp_vec(ph, st));
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    exp_err = 1'b0;
    stall = 1'b0;
  endtask

  task automatic run_cmd(cmd_t c, int pre, int sph, int sn, bit hold);
    int ph[$];
    logic [31:0] r;
    logic [15:0] v;
    {cmd_op, cmd_alu, cmd_shift, cmd_rd, cmd_rn, cmd_rm, cmd_imm} = c;
    cmd_valid = 1'b1;
    repeat (pre) tick(0, 1'b1);
    tick(0, 1'b0);
    cur = c;
    if (!hold) begin
      cmd_valid = 1'b0;
      r = $urandom;
      {cmd_op, cmd_alu, cmd_shift, cmd_rd, cmd_rn, cmd_rm, cmd_imm} = r[23:0];
    end
    case (c.op)
      3'd1: ph = {4};
      3'd2: ph = {2, 3, 4};
      3'd3: ph = {1, 2, 3, 4};
      3'd4: ph = {1, 2, 3};
      default: ph = {};
    endcase
    foreach (ph[i]) begin
      if (i == sph) repeat (sn) tick(ph[i], 1'b1);
      tick(ph[i], 1'b0);
    end
    exp_done = 1'b1;
    exp_err = c.op > 3'd4;
    v = alu_f(c.op == 3'd2 ? 16'd0 : exp_r[c.rn], shf(exp_r[c.rm], c.sh), c.op == 3'd3 ? c.alu : 2'd0);
    if (c.op == 3'd1) exp_r[c.rd] = sext(c.imm);
    if (c.op == 3'd2 || c.op == 3'd3) exp_r[c.rd] = v;
    if (c.op == 3'd4) exp_z = exp_r[c.rn] - shf(exp_r[c.rm], c.sh) == 16'd0;
    if (c.op >= 3'd1 && c.op <= 3'd3)
      check($sformatf("reg r%0d op%0d", c.rd, c.op), {22'd0, dp_r[c.rd]}, {22'd0, exp_r[c.rd]});
    if (c.op == 3'd4) check("status", {37'd0, dp_z}, {37'd0, exp_z});
  endtask

  function automatic cmd_t mk(int op, int alu, int sh, int rd, int rn, int rm, int imm);
    cmd_t c;
    c.op = 3'(op);
    c.alu = 2'(alu);
    c.sh = 2'(sh);
    c.rd = 3'(rd);
    c.rn = 3'(rn);
    c.rm = 3'(rm);
    c.imm = 8'(imm);
    return c;
  endfunction

  initial begin
    cmd_t c;
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    tick(0, 1'b0);
    run_cmd(mk(1, 0, 0, 3, 0, 0, 8'hF5), 0, -1, 0, 1'b0);
    run_cmd(mk(1, 0, 0, 0, 0, 0, 7), 0, -1, 0, 1'b0);
    run_cmd(mk(1, 0, 0, 1, 0, 0, 3), 0, -1, 0, 1'b0);
    check("movi r3", {22'd0, dp_r[3]}, {22'd0, 16'hFFF5});
    run_cmd(mk(3, 0, 1, 2, 0, 1, 0), 0, -1, 0, 1'b0);
    check("alu r2", {22'd0, dp_r[2]}, {22'd0, 16'd13});
    run_cmd(mk(4, 0, 0, 0, 4, 4, 0), 0, -1, 0, 1'b0);
    check("cmp z", {37'd0, dp_z}, {37'd0, 1'b1});
    run_cmd(mk(3, 1, 0, 7, 2, 1, 0), 0, 1, 3, 1'b0);
    check("sub r7", {22'd0, dp_r[7]}, {22'd0, 16'd10});
    run_cmd(mk(6, 0, 0, 0, 0, 0, 0), 0, -1, 0, 1'b0);
    run_cmd(mk(2, 0, 3, 4, 0, 3, 0), 0, -1, 0, 1'b0);
    run_cmd(mk(0, 0, 0, 0, 0, 0, 8'h80), 2, -1, 0, 1'b0);
    run_cmd(mk(3, 2, 2, 6, 1, 3, 0), 1, -1, 0, 1'b1);
    run_cmd(mk(3, 2, 2, 6, 1, 3, 0), 0, 2, 1, 1'b0);
    // abort an ALU command with reset while it is in the execute stage
    c = mk(3, 0, 0, 5, 0, 1, 8'h11);
    {cmd_op, cmd_alu, cmd_shift, cmd_rd, cmd_rn, cmd_rm, cmd_imm} = c;
    cmd_valid = 1'b1;
    tick(0, 1'b0);
    cur = c;
    cmd_valid = 1'b0;
    tick(1, 1'b0);
    tick(2, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check("rst exec", act, exp_vec(3, 1'b0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cur = '0;
    tick(0, 1'b0);
    tick(0, 1'b0);
    check("rst no write r5", {22'd0, dp_r[5]}, {22'd0, exp_r[5]});
    for (int n = 0; n < 24; n++) begin
      r = $urandom;
      c = r[23:0];
      run_cmd(c, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
    end
    tick(0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle controller that accepts one decoded command at a time over a valid/ready handshake.
- Drives every datapath control input (readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, writenum, write, vsel, datapath_in) through the register-read, execute and writeback stages.
- Replaces the manual switch-driven control path: one command produces a complete register-to-register operation on the existing 16-bit, 8-register datapath.

Parameters:
- DATA_W, 16, datapath_in width.
- IMM_W, 8, immediate width; sign-extended to DATA_W.
- RN_W, 3, register-number width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  synchronous reset, active low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  000 NOP, 001 MOVI, 010 MOVR, 011 ALU, 100 CMP, 101-111 illegal.
- cmd_alu  in  2  ALUop for ALU: 00 add, 01 sub, 10 and, 11 not-B.
- cmd_shift  in  2  shifter code applied to the B operand.
- cmd_rd, cmd_rn, cmd_rm  in  RN_W each  destination, A source, B source.
- cmd_imm  in  IMM_W  immediate for MOVI.
- stall  in  1  freeze sequencing.
- readnum, writenum  out  RN_W  datapath register selects.
- loada, loadb, loadc, loads, asel, bsel, write, vsel  out  1  datapath controls.
- shift, ALUop  out  2  datapath controls.
- datapath_in  out  DATA_W  sign-extended captured immediate.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, illegal op.

Behaviour:
- States: IDLE, RD_A, RD_B, EXEC, WB.
- Reset: IDLE, command register cleared to 0. Outputs: every enable 0, readnum/writenum/shift/ALUop 0, datapath_in 0, done 0, err 0, busy 0, cmd_ready 1.
- Reset mid-command aborts it with no further enables and no done.

Handshake and capture:
- cmd_ready = (state == IDLE) & ~stall.
- Accept on a rising edge with cmd_valid & cmd_ready. All cmd_* fields are captured into a register; outputs use only captured values, so cmd_* may change after acceptance.

Transitions at accept:
- NOP: stays IDLE, done=1 next cycle.
- Illegal op: stays IDLE, err=1 and done=1 next cycle.
- MOVI: -> WB.
- MOVR: -> RD_B.
- ALU, CMP: -> RD_A.

Sequence: RD_A -> RD_B -> EXEC -> WB -> IDLE. CMP goes EXEC -> IDLE.

Per-state controls (Moore; anything not listed is 0):
- RD_A: readnum=rn, loada=1.
- RD_B: readnum=rm, loadb=1.
- EXEC: shift=cmd_shift, bsel=0, loadc=1.
  - ALU: asel=0, ALUop=cmd_alu.
  - MOVR: asel=1 (A operand forced 0), ALUop=00.
  - CMP: asel=0, ALUop=01, loads=1, loadc=0.
- WB: writenum=rd, write=1.
  - MOVI: vsel=1.
  - Otherwise: vsel=0 (C value).

Other outputs:
- datapath_in = sign-extended captured cmd_imm in all states.
- done is registered: high for exactly the one cycle after the last active state, i.e. the first IDLE cycle. A new command may be accepted in that same cycle (back-to-back).

Latency, accept edge to done cycle:
- NOP: 1.
- MOVI: 2.
- MOVR: 4.
- CMP: 4.
- ALU: 5.

Stall:
- While stall=1 the state and captured command hold.
- All load/write enables are forced 0; select/mux outputs keep their values.
- No accept occurs.
- done/err pulses still fall after one cycle.
- On release, the held state's enables reassert for exactly one cycle.

Other rules:
- Only one command is in flight; no queueing.
- cmd_valid asserted while busy is ignored, not lost: it is accepted on return to IDLE if still asserted.

Test Plan:
1. After reset, MOVI rd=3 imm=8'hF5 -> next cycle WB: writenum=3, write=1, vsel=1, datapath_in=16'hFFF5. Following cycle done=1, cmd_ready=1.
2. ALU op=add rd=2 rn=0 rm=1 shift=01 -> consecutive cycles:
   - RD_A: readnum=0, loada=1.
   - RD_B: readnum=1, loadb=1.
   - EXEC: shift=01, ALUop=00, loadc=1.
   - WB: writenum=2, write=1.
   - then done.
   - Datapath model with R0=7, R1=3 gives R2=13.
3. CMP rn=4 rm=4 -> EXEC shows ALUop=01, loads=1, loadc=0. No write in any cycle. done 4 cycles after accept. status=1 in the datapath model.
4. stall=1 asserted during RD_B for 3 cycles -> loadb=0 and readnum held for 3 cycles, then loadb=1 for one cycle. Total latency 5+3=8 cycles.
5. Illegal op 3'b110 -> no enables; err=1 and done=1 for one cycle. Back-to-back MOVR is accepted in that same cycle.
6. resetn=0 for one edge during EXEC of an ALU command -> next cycle IDLE, all enables 0, no done, no write to rd.
